// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU core, the memory map and the sprite DMA engine.
// No logic: carries the CPU request, the DMA bus drive and the memory read-return.
// Timing of every field is defined by oam_dma_ctrl.
interface oam_dma_ctrl_if;
    // CPU outputs observed by the DMA engine
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    // Memory-map read data returned during DMA read cycles
    logic [7:0]  bus_din;
    // DMA engine outputs
    logic        cpu_rdy;
    logic        bus_sel;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_rnw;
    logic        dma_busy;

    // DMA engine view
    modport slave (
        input  cpu_addr, cpu_dout, cpu_rnw, bus_din,
        output cpu_rdy, bus_sel, bus_addr, bus_dout, bus_rnw, dma_busy
    );

    // CPU / memory-map view
    modport master (
        output cpu_addr, cpu_dout, cpu_rnw, bus_din,
        input  cpu_rdy, bus_sel, bus_addr, bus_dout, bus_rnw, dma_busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR halts the CPU and copies one 256-byte page to OAM_DATA_ADDR.
// Latency: DMA owns the bus from the cycle after the trigger; 513 or 514 cycles depending on cycle parity.
// Backpressure: none accepted; the CPU is stalled via cpu_rdy and all CPU activity is ignored while busy.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic          clk_ph1,
    input  logic          rst,
    oam_dma_ctrl_if.slave bus
);

    // The source address is {page, idx}, so the index must be exactly one byte wide.
    localparam int             IDX_W    = $clog2(XFER_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       page;
    logic [7:0]       data_reg;
    logic             parity;
    logic             trigger;

    // A CPU write cycle addressed to the trigger register; reads of it do nothing.
    assign trigger = (bus.cpu_rnw == 1'b0) && (bus.cpu_addr == TRIGGER_ADDR);

    // Free-running even/odd cycle marker; only reset can clear it.
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    // Transfer sequencer: halt, optional align, then 256 read/write pairs.
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            page     <= 8'h00;
            data_reg <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        page  <= bus.cpu_dout;
                        idx   <= '0;
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    // Reads must land on even cycles; an extra dummy read fixes odd alignment.
                    if (parity) begin
                        state <= S_READ;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    state <= S_READ;
                end
                S_READ: begin
                    data_reg <= bus.bus_din;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_READ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus drive decoded straight from registered state so a DMA cycle starts on the edge.
    always_comb begin
        bus.cpu_rdy  = 1'b1;
        bus.bus_sel  = 1'b0;
        bus.bus_addr = 16'h0000;
        bus.bus_dout = data_reg;
        bus.bus_rnw  = 1'b1;
        bus.dma_busy = 1'b0;
        case (state)
            S_HALT, S_ALIGN: begin
                bus.cpu_rdy  = 1'b0;
                bus.bus_sel  = 1'b1;
                bus.dma_busy = 1'b1;
                bus.bus_addr = {page, 8'h00};
            end
            S_READ: begin
                bus.cpu_rdy  = 1'b0;
                bus.bus_sel  = 1'b1;
                bus.dma_busy = 1'b1;
                bus.bus_addr = {page, idx};
            end
            S_WRITE: begin
                bus.cpu_rdy  = 1'b0;
                bus.bus_sel  = 1'b1;
                bus.dma_busy = 1'b1;
                bus.bus_rnw  = 1'b0;
                bus.bus_addr = OAM_DATA_ADDR;
            end
            default: begin
                bus.cpu_rdy  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for the sprite DMA engine with a queued bus-cycle scoreboard.
module tb_oam_dma_ctrl;

    logic clk_ph1 = 1'b0;
    logic rst     = 1'b1;
    logic tb_par  = 1'b0;

    always #5 clk_ph1 = ~clk_ph1;

    oam_dma_ctrl_if dif ();

    oam_dma_ctrl dut (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .bus     (dif)
    );

    // Memory model: every location returns its low address byte XOR A5.
    assign dif.bus_din = dif.bus_addr[7:0] ^ 8'hA5;

    // Even/odd cycle tracker, cleared by reset like the real cycle counter.
    always @(posedge clk_ph1) tb_par <= rst ? 1'b0 : ~tb_par;

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  dout;
        bit          is_wr;
        bit          is_real_rd;
        int          idx;
    } xact_t;

    xact_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        dif.cpu_addr = 16'h8000;
        dif.cpu_dout = 8'h00;
        dif.cpu_rnw  = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        dif.cpu_addr = a;
        dif.cpu_dout = d;
        dif.cpu_rnw  = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},  {31'd0, dif.cpu_rdy},  32'd1);
        check({tag, "_sel"},  {31'd0, dif.bus_sel},  32'd0);
        check({tag, "_busy"}, {31'd0, dif.dma_busy}, 32'd0);
        check({tag, "_addr"}, {16'd0, dif.bus_addr}, 32'h0000);
    endtask

    // Entered at a falling edge with the engine idle; returns at the falling edge
    // of the first idle cycle after the transfer (or after a reset abort).
    // want_par: required HALT-cycle parity, or -1 for whatever the current cycle gives.
    task automatic run_dma(input string tag, input logic [7:0] page, input int want_par,
                           input int inj_at, input logic [7:0] inj_page, input int abort_idx);
        xact_t e;
        bit    align;
        int    cyc;
        if (want_par >= 0) begin
            // The HALT cycle's parity is the opposite of the current one.
            if ((~tb_par) != want_par[0]) @(negedge clk_ph1);
        end
        cpu_write(16'h4014, page);
        @(negedge clk_ph1);
        cpu_idle();
        align = (tb_par == 1'b0);
        e = '{1'b1, {page, 8'h00}, 8'h00, 1'b0, 1'b0, -1};
        sb.push_back(e);
        if (align) sb.push_back(e);
        for (int i = 0; i < 256; i++) begin
            e = '{1'b1, {page, 8'(i)}, 8'h00, 1'b0, 1'b1, i};
            sb.push_back(e);
            e = '{1'b0, 16'h2004, mem({page, 8'(i)}), 1'b1, 1'b0, i};
            sb.push_back(e);
        end
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rdy"},  {31'd0, dif.cpu_rdy},  32'd0);
            check({tag, "_sel"},  {31'd0, dif.bus_sel},  32'd1);
            check({tag, "_busy"}, {31'd0, dif.dma_busy}, 32'd1);
            check({tag, "_rnw"},  {31'd0, dif.bus_rnw},  {31'd0, e.rnw});
            check({tag, "_addr"}, {16'd0, dif.bus_addr}, {16'd0, e.addr});
            if (e.is_wr) check({tag, "_wdat"}, {24'd0, dif.bus_dout}, {24'd0, e.dout});
            if (e.is_real_rd) check({tag, "_rdpar"}, {31'd0, dut.parity}, 32'd0);
            if (cyc == inj_at) cpu_write(16'h4014, inj_page);
            else cpu_idle();
            if (e.is_wr && e.idx == abort_idx) begin
                rst = 1'b1;
                @(negedge clk_ph1);
                rst = 1'b0;
                check_idle({tag, "_abort"});
                check({tag, "_abort_rnw"},  {31'd0, dif.bus_rnw},  32'd1);
                check({tag, "_abort_dout"}, {24'd0, dif.bus_dout}, 32'd0);
                check({tag, "_abort_idx"},  {24'd0, dut.idx},      32'd0);
                sb.delete();
                return;
            end
            cyc++;
            @(negedge clk_ph1);
        end
        check_idle({tag, "_done"});
        check({tag, "_done_idx"}, {24'd0, dut.idx}, 32'd0);
    endtask

    initial begin
        cpu_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk_ph1);
        check_idle("reset");
        check("reset_rnw",  {31'd0, dif.bus_rnw},  32'd1);
        check("reset_dout", {24'd0, dif.bus_dout}, 32'd0);
        check("reset_par",  {31'd0, dut.parity},   32'd0);
        check("reset_idx",  {24'd0, dut.idx},      32'd0);
        rst = 1'b0;
        @(negedge clk_ph1);

        // HALT on odd cycle: 513 cycles, then on even cycle: 514 with an ALIGN read.
        run_dma("t1_odd",  8'h02, 1, -1, 8'h00, -1);
        @(negedge clk_ph1);
        run_dma("t2_even", 8'h02, 0, -1, 8'h00, -1);

        // Near-miss addresses and a read of the trigger register do nothing.
        cpu_write(16'h4015, 8'h55);
        @(negedge clk_ph1);
        check_idle("t3_w4015");
        cpu_write(16'h4013, 8'h55);
        @(negedge clk_ph1);
        check_idle("t3_w4013");
        dif.cpu_addr = 16'h4014;
        dif.cpu_dout = 8'h55;
        dif.cpu_rnw  = 1'b1;
        @(negedge clk_ph1);
        check_idle("t3_r4014");
        cpu_idle();
        @(negedge clk_ph1);
        check_idle("t3_after");

        // Top page: no carry out of $FFFF, last write carries $5A.
        run_dma("t4_pageff", 8'hFF, -1, -1, 8'h00, -1);

        // Reset in the WRITE of index 100, then a clean restart from $0300.
        @(negedge clk_ph1);
        run_dma("t5_abort", 8'h01, -1, -1, 8'h00, 100);
        run_dma("t5_restart", 8'h03, -1, -1, 8'h00, -1);

        // Trigger while busy is ignored; back-to-back trigger on first idle cycle.
        run_dma("t6_busy", 8'h02, -1, 100, 8'h04, -1);
        run_dma("t6_b2b",  8'h04, -1, -1, 8'h00, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
